// File: rtl/temporizador_jogada.sv
// Round timer: counts down a per-round budget in prescaler ticks, drives the
// prescaler clear/enable, and ends the round on player action or timeout.
module temporizador_jogada #(
  parameter int LIMITE = 10,
  parameter int ALERTA = 3,
  parameter int W      = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         pausar,
  input  logic         jogada,
  input  logic         tick,
  output logic         zera_contador,
  output logic         conta_contador,
  output logic [W-1:0] tempo_restante,
  output logic         alerta,
  output logic         timeout,
  output logic         pronto,
  output logic [2:0]   db_estado
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    PREPARA   = 3'd1,
    CONTANDO  = 3'd2,
    PAUSADO   = 3'd3,
    ESGOTADO  = 3'd4,
    CONCLUIDO = 3'd5
  } estado_t;

  localparam logic [W-1:0] LIM_W = W'(LIMITE);
  localparam logic [W-1:0] ALR_W = W'(ALERTA);
  localparam logic [W-1:0] UM_W  = W'(1);

  estado_t        estado_q, estado_d;
  logic [W-1:0]   tempo_q,  tempo_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      tempo_q  <= LIM_W;
    end else begin
      estado_q <= estado_d;
      tempo_q  <= tempo_d;
    end
  end

  // Every entry into PREPARA reloads the budget, whichever state it comes from.
  always_comb begin
    estado_d = estado_q;
    tempo_d  = tempo_q;
    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          estado_d = PREPARA;
          tempo_d  = LIM_W;
        end
      end
      PREPARA: estado_d = CONTANDO;
      CONTANDO: begin
        if (iniciar) begin
          estado_d = PREPARA;
          tempo_d  = LIM_W;
        end else if (jogada) begin
          estado_d = CONCLUIDO;
        end else if (pausar) begin
          estado_d = PAUSADO;
        end else if (tick) begin
          if (tempo_q > UM_W) begin
            tempo_d = tempo_q - UM_W;
          end else begin
            tempo_d  = '0;
            estado_d = ESGOTADO;
          end
        end
      end
      PAUSADO: begin
        if (iniciar) begin
          estado_d = PREPARA;
          tempo_d  = LIM_W;
        end else if (jogada) begin
          estado_d = CONCLUIDO;
        end else if (!pausar) begin
          estado_d = CONTANDO;
        end
      end
      ESGOTADO, CONCLUIDO: begin
        if (iniciar) begin
          estado_d = PREPARA;
          tempo_d  = LIM_W;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Moore outputs: decoded only from registered state and count.
  always_comb begin
    zera_contador  = (estado_q == OCIOSO) || (estado_q == PREPARA);
    conta_contador = (estado_q == CONTANDO);
    alerta         = ((estado_q == CONTANDO) || (estado_q == PAUSADO)) &&
                     (tempo_q != '0) && (tempo_q <= ALR_W);
    timeout        = (estado_q == ESGOTADO);
    pronto         = (estado_q == CONCLUIDO);
    tempo_restante = tempo_q;
    db_estado      = estado_q;
  end

endmodule

// File: tb/tb_temporizador_jogada.sv
// Bench for temporizador_jogada: directed scenarios plus randomized traffic,
// compared against an event-level reference model of the round timer.
module tb_temporizador_jogada;

  logic clock = 1'b0;
  logic reset = 1'b1, iniciar = 1'b0, pausar = 1'b0, jogada = 1'b0, tick = 1'b0;

  logic       z0, c0, a0, t0, p0;
  logic [3:0] tr0;
  logic [2:0] db0;
  logic       z1, c1, a1, t1, p1;
  logic [3:0] tr1;
  logic [2:0] db1;

  int total = 0;
  int bad   = 0;
  int ms0, mt0, ms1, mt1;
  bit u1_alerta_seen = 1'b0;

  always #5 clock = ~clock;

  temporizador_jogada #(.LIMITE(10), .ALERTA(3), .W(4)) u0 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar),
    .jogada(jogada), .tick(tick), .zera_contador(z0), .conta_contador(c0),
    .tempo_restante(tr0), .alerta(a0), .timeout(t0), .pronto(p0), .db_estado(db0));

  temporizador_jogada #(.LIMITE(1), .ALERTA(0), .W(4)) u1 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar),
    .jogada(jogada), .tick(tick), .zera_contador(z1), .conta_contador(c1),
    .tempo_restante(tr1), .alerta(a1), .timeout(t1), .pronto(p1), .db_estado(db1));

  wire [12:0] o0 = {z0, c0, tr0, a0, t0, p0, db0};
  wire [12:0] o1 = {z1, c1, tr1, a1, t1, p1, db1};

  always @(negedge clock) if (a1 === 1'b1) u1_alerta_seen = 1'b1;

  // Reference model: state codes 0..5, remaining budget as plain integer.
  task automatic model_step(inout int s, inout int t, input int lim);
    if (reset) begin
      s = 0; t = lim;
    end else begin
      case (s)
        0: if (iniciar) begin s = 1; t = lim; end
        1: s = 2;
        2: if (iniciar) begin s = 1; t = lim; end
           else if (jogada) s = 5;
           else if (pausar) s = 3;
           else if (tick) begin
             t = t - 1;
             if (t <= 0) begin t = 0; s = 4; end
           end
        3: if (iniciar) begin s = 1; t = lim; end
           else if (jogada) s = 5;
           else if (!pausar) s = 2;
        default: if (iniciar) begin s = 1; t = lim; end
      endcase
    end
  endtask

  function automatic logic [12:0] expv(input int s, input int t, input int al);
    logic z, c, a, to, p;
    z  = (s == 0) || (s == 1);
    c  = (s == 2);
    a  = ((s == 2) || (s == 3)) && (t > 0) && (t <= al);
    to = (s == 4);
    p  = (s == 5);
    return {z, c, 4'(t), a, to, p, 3'(s)};
  endfunction

  task automatic cyc();
    @(posedge clock);
    model_step(ms0, mt0, 10);
    model_step(ms1, mt1, 1);
    #1;
  endtask

  task automatic drive(input logic r, input logic i, input logic p, input logic j, input logic t);
    reset = r; iniciar = i; pausar = p; jogada = j; tick = t;
    cyc();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    total++;
    if (o0 !== 13'b1_0_1010_0_0_0_000) begin
      bad++; $display("FAIL reset_state: got=%b want=%b", o0, 13'b1_0_1010_0_0_0_000);
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (o0 !== expv(ms0, mt0, 3)) begin
      bad++; $display("FAIL reset_idle: got=%b want=%b", o0, expv(ms0, mt0, 3));
    end
  endtask

  task automatic test_countdown();
    int alerts;
    alerts = 0;
    drive(0, 1, 0, 0, 0);
    total++;
    if (db0 !== 3'd1 || z0 !== 1'b1) begin
      bad++; $display("FAIL cd_prepara: got db=%0d z=%b want db=1 z=1", db0, z0);
    end
    for (int k = 0; k < 10; k++) begin
      for (int g = 0; g < 4; g++) begin
        drive(0, 0, 0, 0, 0);
        if (a0 === 1'b1 && g == 0) alerts++;
        total++;
        if (o0 !== expv(ms0, mt0, 3)) begin
          bad++; $display("FAIL cd_idle k=%0d: got=%b want=%b", k, o0, expv(ms0, mt0, 3));
        end
      end
      drive(0, 0, 0, 0, 1);
      total++;
      if (tr0 !== 4'(9 - k)) begin
        bad++; $display("FAIL cd_tick k=%0d: got tempo=%0d want=%0d", k, tr0, 9 - k);
      end
    end
    total++;
    if (t0 !== 1'b1 || db0 !== 3'd4 || c0 !== 1'b0) begin
      bad++; $display("FAIL cd_timeout: got t=%b db=%0d c=%b want 1 4 0", t0, db0, c0);
    end
    total++;
    if (alerts != 3) begin
      bad++; $display("FAIL cd_alerta_count: got=%0d want=3", alerts);
    end
    drive(0, 0, 0, 1, 1);
    total++;
    if (o0 !== 13'b0_0_0000_0_1_0_100) begin
      bad++; $display("FAIL cd_esgotado_hold: got=%b want=%b", o0, 13'b0_0_0000_0_1_0_100);
    end
  endtask

  task automatic start_round();
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_jogada();
    start_round();
    for (int k = 0; k < 4; k++) begin drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 0); end
    drive(0, 0, 0, 1, 0);
    total++;
    if (db0 !== 3'd5 || p0 !== 1'b1 || tr0 !== 4'd6) begin
      bad++; $display("FAIL jogada_end: got db=%0d p=%b tempo=%0d want 5 1 6", db0, p0, tr0);
    end
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 1);
    total++;
    if (o0 !== expv(ms0, mt0, 3) || tr0 !== 4'd6) begin
      bad++; $display("FAIL jogada_frozen: got=%b want=%b", o0, expv(ms0, mt0, 3));
    end
  endtask

  task automatic test_pause();
    start_round();
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, 0, k[0]);
      total++;
      if (tr0 !== 4'd8 || c0 !== 1'b0 || db0 !== 3'd3) begin
        bad++; $display("FAIL pause_hold k=%0d: got tempo=%0d c=%b db=%0d want 8 0 3", k, tr0, c0, db0);
      end
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (db0 !== 3'd2 || c0 !== 1'b1) begin
      bad++; $display("FAIL pause_release: got db=%0d c=%b want 2 1", db0, c0);
    end
    drive(0, 0, 0, 0, 1);
    total++;
    if (tr0 !== 4'd7) begin
      bad++; $display("FAIL pause_next_tick: got=%0d want=7", tr0);
    end
  endtask

  task automatic test_simultaneous();
    start_round();
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    total++;
    if (db0 !== 3'd3 || tr0 !== 4'd5) begin
      bad++; $display("FAIL sim_pause_tick: got db=%0d tempo=%0d want 3 5", db0, tr0);
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    total++;
    if (db0 !== 3'd5 || tr0 !== 4'd5) begin
      bad++; $display("FAIL sim_jogada_pause: got db=%0d tempo=%0d want 5 5", db0, tr0);
    end
    start_round();
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 0, 1, 0);
    total++;
    if (db0 !== 3'd1 || tr0 !== 4'd10 || z0 !== 1'b1) begin
      bad++; $display("FAIL sim_iniciar_jogada: got db=%0d tempo=%0d z=%b want 1 10 1", db0, tr0, z0);
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (z0 !== 1'b0 || db0 !== 3'd2) begin
      bad++; $display("FAIL sim_zera_one_cycle: got z=%b db=%0d want 0 2", z0, db0);
    end
  endtask

  task automatic test_reset_midround();
    start_round();
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    total++;
    if (o0 !== 13'b1_0_1010_0_0_0_000) begin
      bad++; $display("FAIL reset_mid: got=%b want=%b", o0, 13'b1_0_1010_0_0_0_000);
    end
    start_round();
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    total++;
    if (db0 !== 3'd2 || tr0 !== 4'd10 || t0 !== 1'b0) begin
      bad++; $display("FAIL restart_esgotado: got db=%0d tempo=%0d t=%b want 2 10 0", db0, tr0, t0);
    end
  endtask

  task automatic test_random();
    logic p;
    p = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) p = ~p;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0, p,
            $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
      total++;
      if (o0 !== expv(ms0, mt0, 3)) begin
        bad++; $display("FAIL rand_u0 k=%0d: got=%b want=%b", k, o0, expv(ms0, mt0, 3));
      end
      total++;
      if (o1 !== expv(ms1, mt1, 0)) begin
        bad++; $display("FAIL rand_u1 k=%0d: got=%b want=%b", k, o1, expv(ms1, mt1, 0));
      end
    end
  endtask

  task automatic test_limite1();
    drive(1, 0, 0, 0, 0);
    start_round();
    total++;
    if (db1 !== 3'd2 || tr1 !== 4'd1 || a1 !== 1'b0) begin
      bad++; $display("FAIL lim1_counting: got db=%0d tempo=%0d a=%b want 2 1 0", db1, tr1, a1);
    end
    drive(0, 0, 0, 0, 1);
    total++;
    if (tr1 !== 4'd0 || t1 !== 1'b1 || db1 !== 3'd4) begin
      bad++; $display("FAIL lim1_first_tick: got tempo=%0d t=%b db=%0d want 0 1 4", tr1, t1, db1);
    end
    total++;
    if (u1_alerta_seen) begin
      bad++; $display("FAIL lim1_alerta_never: got=1 want=0");
    end
  endtask

  initial begin
    ms0 = 0; mt0 = 10; ms1 = 0; mt1 = 1;
    test_reset();
    test_countdown();
    test_jogada();
    test_pause();
    test_simultaneous();
    test_reset_midround();
    test_random();
    test_limite1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
